// File: rtl/rv32i_types.sv
// Shared result/CDB types and source numbering for the execution back end.
package rv32i_types;

  localparam int PR_BITS_DEFAULT  = 5;
  localparam int ROB_BITS_DEFAULT = 4;

  // Function-unit result sources, in arbitration index order.
  localparam int BASE_SRC   = 0;
  localparam int MUL_SRC    = 1;
  localparam int DIV_SRC    = 2;
  localparam int BR_SRC     = 3;
  localparam int LS_SRC     = 4;
  localparam int NUM_FU_SRC = 5;

  typedef struct packed {
    logic [PR_BITS_DEFAULT-1:0]  pr_dest;
    logic [ROB_BITS_DEFAULT-1:0] rob_idx;
    logic [31:0]                 rd_data;
  } fu_result_t;

  typedef struct packed {
    logic                        ready;
    logic [PR_BITS_DEFAULT-1:0]  pr_dest;
    logic [ROB_BITS_DEFAULT-1:0] rob_idx;
    logic [31:0]                 rd_data;
  } cdb_t;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_select.sv
// Round-robin selector: grants up to CDB_COUNT held sources, scanning from
// rr_ptr with wrap-around, and reports which source feeds each lane.
module cdb_rr_select #(
  parameter int SRC_COUNT = 5,
  parameter int CDB_COUNT = 1,
  localparam int PTR_W    = rv32i_types::ptr_bits(SRC_COUNT)
) (
  input  logic [SRC_COUNT-1:0]            held,
  input  logic [PTR_W-1:0]                rr_ptr,
  output logic [SRC_COUNT-1:0]            grant,
  output logic [CDB_COUNT-1:0]            lane_valid,
  output logic [CDB_COUNT-1:0][PTR_W-1:0] lane_src,
  output logic [PTR_W-1:0]                rr_ptr_next
);

  int n_granted;
  int scan_src;

  // Walk sources in scan order; the k-th held source found takes lane k.
  always_comb begin
    grant       = '0;
    lane_valid  = '0;
    lane_src    = '0;
    rr_ptr_next = rr_ptr;
    n_granted   = 0;
    scan_src    = 0;
    for (int j = 0; j < SRC_COUNT; j++) begin
      scan_src = int'(rr_ptr) + j;
      if (scan_src >= SRC_COUNT) scan_src = scan_src - SRC_COUNT;
      for (int i = 0; i < SRC_COUNT; i++) begin
        if (i == scan_src && held[i] && n_granted < CDB_COUNT) begin
          grant[i] = 1'b1;
          for (int k = 0; k < CDB_COUNT; k++) begin
            if (k == n_granted) begin
              lane_valid[k] = 1'b1;
              lane_src[k]   = PTR_W'(i);
            end
          end
          // Pointer moves just past the last winner so it loses priority next.
          rr_ptr_next = (i == SRC_COUNT - 1) ? '0 : PTR_W'(i + 1);
          n_granted   = n_granted + 1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per function-unit source,
// round-robin broadcast of up to CDB_COUNT held results per cycle.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int SRC_COUNT = NUM_FU_SRC,
  parameter int CDB_COUNT = 1,
  parameter int PR_BITS   = PR_BITS_DEFAULT,
  parameter int ROB_BITS  = ROB_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [SRC_COUNT-1:0] src_valid,
  input  fu_result_t           src_result [SRC_COUNT],
  output logic [SRC_COUNT-1:0] src_ready,
  output cdb_t                 cdb [CDB_COUNT]
);

  localparam int PTR_W = ptr_bits(SRC_COUNT);

  // The struct widths are fixed by the shared package; catch mismatched overrides.
  if (PR_BITS != PR_BITS_DEFAULT || ROB_BITS != ROB_BITS_DEFAULT) begin : g_bad_widths
    $error("cdb_arbiter: PR_BITS/ROB_BITS must match rv32i_types field widths");
  end
  if (CDB_COUNT < 1 || CDB_COUNT > SRC_COUNT) begin : g_bad_lanes
    $error("cdb_arbiter: CDB_COUNT must be in 1..SRC_COUNT");
  end

  logic [SRC_COUNT-1:0]            held_q, held_d;
  fu_result_t                      hold_data_q [SRC_COUNT];
  fu_result_t                      hold_data_d [SRC_COUNT];
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [SRC_COUNT-1:0]            grant;
  logic [CDB_COUNT-1:0]            lane_valid;
  logic [CDB_COUNT-1:0][PTR_W-1:0] lane_src;
  logic [PTR_W-1:0]                rr_ptr_next;
  logic [SRC_COUNT-1:0]            accept;

  cdb_rr_select #(
    .SRC_COUNT(SRC_COUNT),
    .CDB_COUNT(CDB_COUNT)
  ) u_select (
    .held       (held_q),
    .rr_ptr     (rr_ptr_q),
    .grant      (grant),
    .lane_valid (lane_valid),
    .lane_src   (lane_src),
    .rr_ptr_next(rr_ptr_next)
  );

  // A source may hand over a result when its slot is empty or being drained now.
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      src_ready[i] = ~rst & ~flush & (~held_q[i] | grant[i]);
    end
    accept = src_valid & src_ready;
  end

  // Next holding state: accept overrides grant-clear so a winner can refill with no bubble.
  always_comb begin
    held_d      = held_q;
    hold_data_d = hold_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (rst) begin
      held_d   = '0;
      rr_ptr_d = '0;
    end else if (flush) begin
      held_d = '0;
    end else begin
      held_d   = (held_q & ~grant) | accept;
      rr_ptr_d = rr_ptr_next;
      for (int i = 0; i < SRC_COUNT; i++) begin
        if (accept[i]) hold_data_d[i] = src_result[i];
      end
    end
  end

  // State registers; the data slots need no reset because held_q qualifies them.
  always_ff @(posedge clk) begin
    held_q      <= held_d;
    rr_ptr_q    <= rr_ptr_d;
    hold_data_q <= hold_data_d;
  end

  // Lane muxes read holding registers only, so src_* never reaches the bus combinationally.
  always_comb begin
    for (int k = 0; k < CDB_COUNT; k++) begin
      cdb[k] = '0;
      if (!rst && !flush && lane_valid[k]) begin
        cdb[k].ready   = 1'b1;
        cdb[k].pr_dest = hold_data_q[lane_src[k]].pr_dest;
        cdb[k].rob_idx = hold_data_q[lane_src[k]].rob_idx;
        cdb[k].rd_data = hold_data_q[lane_src[k]].rd_data;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: single-lane and dual-lane instances share stimulus
// and are each compared against a queue-based round-robin reference model.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int NS = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [NS-1:0] src_valid;
  fu_result_t src_result [NS];
  logic [NS-1:0] rdy1, rdy2;
  cdb_t       cdb1 [1];
  cdb_t       cdb2 [2];

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = one-lane DUT, 1 = two-lane DUT.
  bit          m_held  [2][NS];
  fu_result_t  m_data  [2][NS];
  int          m_rr    [2];
  cdb_t        e_cdb   [2][2];
  logic [NS-1:0] e_rdy [2];
  bit          e_grant [2][NS];
  int          e_last  [2];

  always #5 clk = ~clk;

  cdb_arbiter #(.SRC_COUNT(NS), .CDB_COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .src_valid(src_valid),
    .src_result(src_result), .src_ready(rdy1), .cdb(cdb1)
  );

  cdb_arbiter #(.SRC_COUNT(NS), .CDB_COUNT(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .src_valid(src_valid),
    .src_result(src_result), .src_ready(rdy2), .cdb(cdb2)
  );

  function automatic fu_result_t rand_res();
    fu_result_t r;
    r.pr_dest = 5'($urandom);
    r.rob_idx = 4'($urandom);
    r.rd_data = $urandom;
    return r;
  endfunction

  function automatic fu_result_t mk_res(input int pr, input int rob, input logic [31:0] data);
    fu_result_t r;
    r.pr_dest = 5'(pr);
    r.rob_idx = 4'(rob);
    r.rd_data = data;
    return r;
  endfunction

  // Expected outputs: the first <lanes> held sources, scanning from rr with wrap.
  function automatic void model_eval();
    for (int d = 0; d < 2; d++) begin
      int order[$];
      int lanes;
      int s;
      lanes = d + 1;
      order = {};
      for (int j = 0; j < NS; j++) begin
        s = (m_rr[d] + j) % NS;
        if (m_held[d][s] && order.size() < lanes) order.push_back(s);
      end
      for (int i = 0; i < NS; i++) e_grant[d][i] = 1'b0;
      e_cdb[d][0] = '0;
      e_cdb[d][1] = '0;
      e_rdy[d]    = '0;
      e_last[d]   = -1;
      if (!rst && !flush) begin
        foreach (order[k]) begin
          e_grant[d][order[k]] = 1'b1;
          e_cdb[d][k]          = {1'b1, m_data[d][order[k]]};
          e_last[d]            = order[k];
        end
        for (int i = 0; i < NS; i++) e_rdy[d][i] = !m_held[d][i] || e_grant[d][i];
      end
    end
  endfunction

  function automatic void model_commit();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < NS; i++) m_held[d][i] = 1'b0;
        m_rr[d] = 0;
      end else if (flush) begin
        for (int i = 0; i < NS; i++) m_held[d][i] = 1'b0;
      end else begin
        for (int i = 0; i < NS; i++) begin
          if (src_valid[i] && e_rdy[d][i]) begin
            m_held[d][i] = 1'b1;
            m_data[d][i] = src_result[i];
          end else if (e_grant[d][i]) begin
            m_held[d][i] = 1'b0;
          end
        end
        if (e_last[d] >= 0) m_rr[d] = (e_last[d] + 1) % NS;
      end
    end
  endfunction

  task automatic eval_phase();
    @(negedge clk);
    model_eval();
  endtask

  task automatic commit_phase();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; src_valid = '0;
    eval_phase();
    commit_phase();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; src_valid = '1;
    for (int i = 0; i < NS; i++) src_result[i] = rand_res();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin rst = 1'b0; src_valid = '0; end
      eval_phase();
      if ({cdb1[0], rdy1} !== {e_cdb[0][0], e_rdy[0]}) begin
        errors++; $display("FAIL reset model1 got=%h exp=%h", {cdb1[0], rdy1}, {e_cdb[0][0], e_rdy[0]});
      end
      checks++;
      if ({cdb2[0], cdb2[1], rdy2} !== {e_cdb[1][0], e_cdb[1][1], e_rdy[1]}) begin
        errors++; $display("FAIL reset model2 got=%h exp=%h", {cdb2[0], cdb2[1], rdy2}, {e_cdb[1][0], e_cdb[1][1], e_rdy[1]});
      end
      checks++;
      if (c < 2) begin
        if ({rdy1, rdy2, cdb1[0], cdb2[0], cdb2[1]} !== '0) begin
          errors++; $display("FAIL reset outputs got=%h exp=0", {rdy1, rdy2, cdb1[0], cdb2[0], cdb2[1]});
        end
        checks++;
      end else begin
        if (dut1.rr_ptr_q !== 3'd0 || dut2.rr_ptr_q !== 3'd0) begin
          errors++; $display("FAIL reset rr_ptr got=%0d/%0d exp=0", dut1.rr_ptr_q, dut2.rr_ptr_q);
        end
        checks++;
      end
      commit_phase();
    end
  endtask

  task automatic test_single();
    cdb_t exp;
    exp = {1'b1, mk_res(7, 3, 32'hDEADBEEF)};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      src_valid = (c == 0) ? 5'b00100 : 5'b00000;
      src_result[2] = mk_res(7, 3, 32'hDEADBEEF);
      eval_phase();
      if ({cdb1[0], rdy1} !== {e_cdb[0][0], e_rdy[0]}) begin
        errors++; $display("FAIL single model1 got=%h exp=%h", {cdb1[0], rdy1}, {e_cdb[0][0], e_rdy[0]});
      end
      checks++;
      if ({cdb2[0], cdb2[1], rdy2} !== {e_cdb[1][0], e_cdb[1][1], e_rdy[1]}) begin
        errors++; $display("FAIL single model2 got=%h exp=%h", {cdb2[0], cdb2[1], rdy2}, {e_cdb[1][0], e_cdb[1][1], e_rdy[1]});
      end
      checks++;
      if (c == 1) begin
        if (cdb1[0] !== exp || cdb2[0] !== exp) begin
          errors++; $display("FAIL single bcast got=%h/%h exp=%h", cdb1[0], cdb2[0], exp);
        end
        checks++;
      end
      if (c == 2) begin
        if (cdb1[0].ready !== 1'b0 || dut1.rr_ptr_q !== 3'd3 || dut2.rr_ptr_q !== 3'd3) begin
          errors++; $display("FAIL single after ready=%b rr=%0d/%0d exp ready=0 rr=3",
                             cdb1[0].ready, dut1.rr_ptr_q, dut2.rr_ptr_q);
        end
        checks++;
      end
      commit_phase();
    end
  endtask

  task automatic test_fairness();
    logic [NS-1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      src_valid = (c <= 6) ? '1 : '0;
      for (int i = 0; i < NS; i++) src_result[i] = rand_res();
      eval_phase();
      if ({cdb1[0], rdy1} !== {e_cdb[0][0], e_rdy[0]}) begin
        errors++; $display("FAIL fair model1 got=%h exp=%h", {cdb1[0], rdy1}, {e_cdb[0][0], e_rdy[0]});
      end
      checks++;
      if ({cdb2[0], cdb2[1], rdy2} !== {e_cdb[1][0], e_cdb[1][1], e_rdy[1]}) begin
        errors++; $display("FAIL fair model2 got=%h exp=%h", {cdb2[0], cdb2[1], rdy2}, {e_cdb[1][0], e_cdb[1][1], e_rdy[1]});
      end
      checks++;
      if (c >= 1 && c <= 6) begin
        exp_rdy = 5'b00001 << ((c - 1) % NS);
        if (rdy1 !== exp_rdy || cdb1[0].ready !== 1'b1) begin
          errors++; $display("FAIL fair grant cyc=%0d got rdy=%b ready=%b exp rdy=%b ready=1",
                             c, rdy1, cdb1[0].ready, exp_rdy);
        end
        checks++;
      end
      commit_phase();
    end
  endtask

  task automatic test_dual();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       src_valid = 5'b01000;
        2:       src_valid = 5'b11010;
        default: src_valid = 5'b00000;
      endcase
      for (int i = 0; i < NS; i++) src_result[i] = mk_res(10 + i, i, 32'h1000 + i);
      eval_phase();
      if ({cdb1[0], rdy1} !== {e_cdb[0][0], e_rdy[0]}) begin
        errors++; $display("FAIL dual model1 got=%h exp=%h", {cdb1[0], rdy1}, {e_cdb[0][0], e_rdy[0]});
      end
      checks++;
      if ({cdb2[0], cdb2[1], rdy2} !== {e_cdb[1][0], e_cdb[1][1], e_rdy[1]}) begin
        errors++; $display("FAIL dual model2 got=%h exp=%h", {cdb2[0], cdb2[1], rdy2}, {e_cdb[1][0], e_cdb[1][1], e_rdy[1]});
      end
      checks++;
      if (c == 3) begin
        if (dut2.rr_ptr_q !== 3'd4 || cdb2[0].ready !== 1'b1 || cdb2[0].pr_dest !== 5'd14 ||
            cdb2[1].ready !== 1'b1 || cdb2[1].pr_dest !== 5'd11 || rdy2[3] !== 1'b0) begin
          errors++; $display("FAIL dual lanes rr=%0d l0=%b/%0d l1=%b/%0d rdy3=%b exp rr=4 l0=1/14 l1=1/11 rdy3=0",
                             dut2.rr_ptr_q, cdb2[0].ready, cdb2[0].pr_dest, cdb2[1].ready, cdb2[1].pr_dest, rdy2[3]);
        end
        checks++;
      end
      if (c == 4) begin
        if (dut2.rr_ptr_q !== 3'd2 || cdb2[0].ready !== 1'b1 || cdb2[0].pr_dest !== 5'd13 ||
            cdb2[1].ready !== 1'b0) begin
          errors++; $display("FAIL dual next rr=%0d l0=%b/%0d l1=%b exp rr=2 l0=1/13 l1=0",
                             dut2.rr_ptr_q, cdb2[0].ready, cdb2[0].pr_dest, cdb2[1].ready);
        end
        checks++;
      end
      commit_phase();
    end
  endtask

  task automatic test_replace();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      src_valid = (c <= 1) ? 5'b00001 : 5'b00000;
      src_result[0] = mk_res((c == 0) ? 5 : 9, c, 32'hA0 + c);
      eval_phase();
      if ({cdb1[0], rdy1} !== {e_cdb[0][0], e_rdy[0]}) begin
        errors++; $display("FAIL replace model1 got=%h exp=%h", {cdb1[0], rdy1}, {e_cdb[0][0], e_rdy[0]});
      end
      checks++;
      if ({cdb2[0], cdb2[1], rdy2} !== {e_cdb[1][0], e_cdb[1][1], e_rdy[1]}) begin
        errors++; $display("FAIL replace model2 got=%h exp=%h", {cdb2[0], cdb2[1], rdy2}, {e_cdb[1][0], e_cdb[1][1], e_rdy[1]});
      end
      checks++;
      if (c == 1) begin
        if (cdb1[0].ready !== 1'b1 || cdb1[0].pr_dest !== 5'd5 || rdy1[0] !== 1'b1) begin
          errors++; $display("FAIL replace old ready=%b pr=%0d rdy0=%b exp 1/5/1", cdb1[0].ready, cdb1[0].pr_dest, rdy1[0]);
        end
        checks++;
      end
      if (c == 2) begin
        if (cdb1[0].ready !== 1'b1 || cdb1[0].pr_dest !== 5'd9 || cdb2[0].pr_dest !== 5'd9) begin
          errors++; $display("FAIL replace new ready=%b pr=%0d/%0d exp 1/9/9", cdb1[0].ready, cdb1[0].pr_dest, cdb2[0].pr_dest);
        end
        checks++;
      end
      commit_phase();
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      flush = (c == 1);
      case (c)
        0:       src_valid = 5'b00101;
        1:       src_valid = 5'b00010;
        default: src_valid = 5'b00000;
      endcase
      for (int i = 0; i < NS; i++) src_result[i] = rand_res();
      eval_phase();
      if ({cdb1[0], rdy1} !== {e_cdb[0][0], e_rdy[0]}) begin
        errors++; $display("FAIL flush model1 got=%h exp=%h", {cdb1[0], rdy1}, {e_cdb[0][0], e_rdy[0]});
      end
      checks++;
      if ({cdb2[0], cdb2[1], rdy2} !== {e_cdb[1][0], e_cdb[1][1], e_rdy[1]}) begin
        errors++; $display("FAIL flush model2 got=%h exp=%h", {cdb2[0], cdb2[1], rdy2}, {e_cdb[1][0], e_cdb[1][1], e_rdy[1]});
      end
      checks++;
      if (c >= 1) begin
        if ({cdb1[0].ready, cdb2[0].ready, cdb2[1].ready} !== 3'b000 ||
            rdy1 !== ((c == 1) ? 5'b00000 : 5'b11111) || rdy2 !== ((c == 1) ? 5'b00000 : 5'b11111)) begin
          errors++; $display("FAIL flush cyc=%0d ready=%b rdy=%b/%b", c,
                             {cdb1[0].ready, cdb2[0].ready, cdb2[1].ready}, rdy1, rdy2);
        end
        checks++;
      end
      commit_phase();
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      rst = (c == 1);
      src_valid = (c == 0) ? 5'b00111 : 5'b00000;
      for (int i = 0; i < NS; i++) src_result[i] = rand_res();
      eval_phase();
      if ({cdb1[0], rdy1} !== {e_cdb[0][0], e_rdy[0]}) begin
        errors++; $display("FAIL rstmid model1 got=%h exp=%h", {cdb1[0], rdy1}, {e_cdb[0][0], e_rdy[0]});
      end
      checks++;
      if ({cdb2[0], cdb2[1], rdy2} !== {e_cdb[1][0], e_cdb[1][1], e_rdy[1]}) begin
        errors++; $display("FAIL rstmid model2 got=%h exp=%h", {cdb2[0], cdb2[1], rdy2}, {e_cdb[1][0], e_cdb[1][1], e_rdy[1]});
      end
      checks++;
      if (c == 1) begin
        if ({rdy1, rdy2, cdb1[0], cdb2[0], cdb2[1]} !== '0) begin
          errors++; $display("FAIL rstmid outputs got=%h exp=0", {rdy1, rdy2, cdb1[0], cdb2[0], cdb2[1]});
        end
        checks++;
      end
      if (c == 2) begin
        if ({cdb1[0].ready, cdb2[0].ready, cdb2[1].ready} !== 3'b000 ||
            dut1.rr_ptr_q !== 3'd0 || dut2.rr_ptr_q !== 3'd0) begin
          errors++; $display("FAIL rstmid after ready=%b rr=%0d/%0d exp ready=000 rr=0",
                             {cdb1[0].ready, cdb2[0].ready, cdb2[1].ready}, dut1.rr_ptr_q, dut2.rr_ptr_q);
        end
        checks++;
      end
      commit_phase();
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      src_valid = 5'($urandom);
      for (int i = 0; i < NS; i++) src_result[i] = rand_res();
      eval_phase();
      if ({cdb1[0], rdy1} !== {e_cdb[0][0], e_rdy[0]}) begin
        errors++; $display("FAIL random model1 cyc=%0d got=%h exp=%h", c, {cdb1[0], rdy1}, {e_cdb[0][0], e_rdy[0]});
      end
      checks++;
      if ({cdb2[0], cdb2[1], rdy2} !== {e_cdb[1][0], e_cdb[1][1], e_rdy[1]}) begin
        errors++; $display("FAIL random model2 cyc=%0d got=%h exp=%h", c, {cdb2[0], cdb2[1], rdy2}, {e_cdb[1][0], e_cdb[1][1], e_rdy[1]});
      end
      checks++;
      commit_phase();
    end
    rst = 1'b0; flush = 1'b0; src_valid = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; src_valid = '0;
    for (int i = 0; i < NS; i++) src_result[i] = '0;
    test_reset();
    test_single();
    test_fairness();
    test_dual();
    test_replace();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
